// File: rtl/bcd_calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// bcd_calc_sequencer_if
// Connects the calculator front-end to the BCD add/subtract datapath.
// Words use sign-nibble encoding: {4'hF, h, t, o} is positive and
// {4'hE, h, t, o} is negative.
//
// Handshake: the master drives firstNumber/secondNumber and raises aluStart
// for exactly one cycle. The operands stay stable until the master leaves
// its done state. The slave answers later with a one-cycle aluDone strobe.
// aluSum and aluCarry must be valid in the cycle that aluDone is high.
// There is no ready/backpressure: one request is outstanding at a time.
//
// Signals:
//   aluStart      master -> slave  one-cycle launch pulse
//   firstNumber   master -> slave  operand A (16 bits)
//   secondNumber  master -> slave  operand B (16 bits)
//   aluSum        slave -> master  result (16 bits)
//   aluCarry      slave -> master  carry out of the hundreds digit
//   aluDone       slave -> master  completion strobe
// ---------------------------------------------------------------------------
interface bcd_calc_sequencer_if;
    logic        aluStart;
    logic [15:0] firstNumber;
    logic [15:0] secondNumber;
    logic [15:0] aluSum;
    logic        aluCarry;
    logic        aluDone;

    modport master (
        output aluStart, firstNumber, secondNumber,
        input  aluSum, aluCarry, aluDone
    );

    modport slave (
        input  aluStart, firstNumber, secondNumber,
        output aluSum, aluCarry, aluDone
    );
endinterface

// File: rtl/bcd_calc_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_calc_sequencer
// Front-end controller for the 3-digit signed BCD calculator. It
// synchronises and debounces five active-low buttons, and it sequences
// operand entry. It launches the datapath, latches the result, and chooses
// the word that is shown on the display.
//
// Optional feature (macro BCD_SEQ_AUTOCLEAR_EN):
//   When the macro is defined, an enter press in DONE returns the block to
//   ENTER_A and clears the operands and the result. The debouncers keep
//   their state. When the macro is not defined, only reset leaves DONE.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   onesBtn, tensBtn, hundredsBtn, sign, enter
//                    raw active-low buttons, asynchronous to clk
//   alu              datapath handshake (master modport)
//   sum, overflow    latched result and carry
//   finished         calculation complete
//   numberOn         0 = operand A shown, 1 = operand B or result shown
//   displayValue     word sent to the seven-segment driver
//   state_dbg        current FSM state:
//                    0 ENTER_A, 1 ENTER_B, 2 START, 3 WAIT, 4 DONE
// ---------------------------------------------------------------------------
module bcd_calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        onesBtn,
    input  logic                        tensBtn,
    input  logic                        hundredsBtn,
    input  logic                        sign,
    input  logic                        enter,
    bcd_calc_sequencer_if.master        alu,
    output logic [15:0]                 sum,
    output logic                        overflow,
    output logic                        finished,
    output logic                        numberOn,
    output logic [15:0]                 displayValue,
    output logic [2:0]                  state_dbg
);

    localparam int          CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ZERO_WORD = 16'hF000;

    // Button index: 0 ones, 1 tens, 2 hundreds, 3 sign, 4 enter
    logic [4:0]    raw;
    logic [4:0]    sync1, sync2;
    logic [4:0]    pressed;
    logic [4:0]    evt;
    logic [CW-1:0] cnt [5];

    assign raw = {enter, sign, hundredsBtn, tensBtn, onesBtn};

    // A debouncer flips its level only after CNT_MAX+1 samples in a row that
    // disagree with that level. A sample that matches the current level
    // clears the run. A level is disagreeing when sync2 == pressed, because
    // a synchronised low means pressed. A press event is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            pressed <= '0;
            evt     <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == pressed[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        cnt[i]     <= '0;
                        pressed[i] <= ~pressed[i];
                        evt[i]     <= ~pressed[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state, next_state;
    logic [15:0] a_q, b_q;
    logic [15:0] a_n, b_n, sum_n, disp_n;
    logic        ovf_n, start_q, start_n, fin_n, num_n;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // The digits wrap on their own with no carry. Flipping bit 12 toggles
    // the sign nibble between F and E.
    function automatic logic [15:0] apply_events(input logic [15:0] w,
                                                 input logic [3:0]  e);
        logic [15:0] r;
        r = w;
        if (e[0]) r[3:0]   = bcd_inc(w[3:0]);
        if (e[1]) r[7:4]   = bcd_inc(w[7:4]);
        if (e[2]) r[11:8]  = bcd_inc(w[11:8]);
        if (e[3]) r[15:12] = w[15:12] ^ 4'h1;
        return r;
    endfunction

    always_comb begin
        next_state = state;
        a_n        = a_q;
        b_n        = b_q;
        sum_n      = sum;
        ovf_n      = overflow;
        case (state)
            ENTER_A: begin
                // enter wins; any other events in the same cycle are dropped
                if (evt[4]) next_state = ENTER_B;
                else        a_n = apply_events(a_q, evt[3:0]);
            end
            ENTER_B: begin
                if (evt[4]) next_state = START;
                else        b_n = apply_events(b_q, evt[3:0]);
            end
            START: next_state = WAIT;
            WAIT: begin
                if (alu.aluDone) begin
                    sum_n      = alu.aluSum;
                    ovf_n      = alu.aluCarry;
                    next_state = DONE;
                end
            end
            DONE: begin
`ifdef BCD_SEQ_AUTOCLEAR_EN
                if (evt[4]) begin
                    next_state = ENTER_A;
                    a_n        = ZERO_WORD;
                    b_n        = ZERO_WORD;
                    sum_n      = ZERO_WORD;
                    ovf_n      = 1'b0;
                end
`endif
            end
            default: next_state = ENTER_A;
        endcase

        // The outputs are computed from the next state, so the registered
        // copies are valid in the first cycle of each state.
        start_n = (next_state == START);
        fin_n   = (next_state == DONE);
        num_n   = (next_state != ENTER_A);
        case (next_state)
            ENTER_A: disp_n = a_n;
            DONE:    disp_n = sum_n;
            default: disp_n = b_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ENTER_A;
            a_q          <= ZERO_WORD;
            b_q          <= ZERO_WORD;
            sum          <= ZERO_WORD;
            overflow     <= 1'b0;
            start_q      <= 1'b0;
            finished     <= 1'b0;
            numberOn     <= 1'b0;
            displayValue <= ZERO_WORD;
        end else begin
            state        <= next_state;
            a_q          <= a_n;
            b_q          <= b_n;
            sum          <= sum_n;
            overflow     <= ovf_n;
            start_q      <= start_n;
            finished     <= fin_n;
            numberOn     <= num_n;
            displayValue <= disp_n;
        end
    end

    assign alu.aluStart     = start_q;
    assign alu.firstNumber  = a_q;
    assign alu.secondNumber = b_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_calc_sequencer
// Directed bench for bcd_calc_sequencer with DEBOUNCE_CYCLES = 4. A small
// responder plays the datapath: it answers each aluStart with aluDone three
// cycles later and returns a programmed result.
// Button index: 0 ones, 1 tens, 2 hundreds, 3 sign, 4 enter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_calc_sequencer;

    localparam logic [2:0] S_ENTER_A = 3'd0;
    localparam logic [2:0] S_ENTER_B = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  btn_n = 5'b11111;
    logic [15:0] sum, displayValue;
    logic        overflow, finished, numberOn;
    logic [2:0]  state_dbg;

    bcd_calc_sequencer_if alu_if ();

    bcd_calc_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .onesBtn      (btn_n[0]),
        .tensBtn      (btn_n[1]),
        .hundredsBtn  (btn_n[2]),
        .sign         (btn_n[3]),
        .enter        (btn_n[4]),
        .alu          (alu_if),
        .sum          (sum),
        .overflow     (overflow),
        .finished     (finished),
        .numberOn     (numberOn),
        .displayValue (displayValue),
        .state_dbg    (state_dbg)
    );

    // ---------------- datapath responder ----------------
    logic [15:0] model_sum   = 16'hF000;
    logic        model_carry = 1'b0;
    logic        alu_auto    = 1'b0;
    logic        manual_done = 1'b0;
    int          start_count = 0;
    int          resp_cnt    = 0;

    assign alu_if.aluSum   = model_sum;
    assign alu_if.aluCarry = model_carry;

    initial alu_if.aluDone = 1'b0;
    always @(negedge clk) begin
        alu_if.aluDone = manual_done;
        if (reset) resp_cnt = 0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) alu_if.aluDone = 1'b1;
        end
        if (alu_if.aluStart === 1'b1) begin
            start_count = start_count + 1;
            if (alu_auto) resp_cnt = 3;
        end
    end

    int total = 0;
    int bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        btn_n = 5'b11111;
        manual_done = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input int idx);
        @(negedge clk);
        btn_n[idx] = 1'b0;
        repeat (10) @(negedge clk);
        btn_n[idx] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_n(input int idx, input int n);
        for (int k = 0; k < n; k++) press(idx);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (state_dbg !== S_ENTER_A) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_ENTER_A); end
        total++; if (alu_if.firstNumber !== 16'hF000) begin bad++; $display("FAIL reset_first got=%h exp=F000", alu_if.firstNumber); end
        total++; if (alu_if.secondNumber !== 16'hF000) begin bad++; $display("FAIL reset_second got=%h exp=F000", alu_if.secondNumber); end
        total++; if (sum !== 16'hF000) begin bad++; $display("FAIL reset_sum got=%h exp=F000", sum); end
        total++; if (displayValue !== 16'hF000) begin bad++; $display("FAIL reset_disp got=%h exp=F000", displayValue); end
        total++; if ({alu_if.aluStart, overflow, finished, numberOn} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {alu_if.aluStart, overflow, finished, numberOn});
        end
    endtask

    task automatic test_add_123_456();
        int s0;
        do_reset();
        press(2); press_n(1, 2); press_n(0, 3);
        total++; if (alu_if.firstNumber !== 16'hF123) begin bad++; $display("FAIL add_first got=%h exp=F123", alu_if.firstNumber); end
        total++; if (displayValue !== 16'hF123) begin bad++; $display("FAIL add_disp_a got=%h exp=F123", displayValue); end
        total++; if (numberOn !== 1'b0) begin bad++; $display("FAIL add_numon_a got=%b exp=0", numberOn); end
        press(4);
        total++; if (state_dbg !== S_ENTER_B) begin bad++; $display("FAIL add_state_b got=%0d exp=%0d", state_dbg, S_ENTER_B); end
        total++; if (numberOn !== 1'b1) begin bad++; $display("FAIL add_numon_b got=%b exp=1", numberOn); end
        press_n(2, 4); press_n(1, 5); press_n(0, 6);
        total++; if (alu_if.secondNumber !== 16'hF456) begin bad++; $display("FAIL add_second got=%h exp=F456", alu_if.secondNumber); end
        total++; if (displayValue !== 16'hF456) begin bad++; $display("FAIL add_disp_b got=%h exp=F456", displayValue); end
        model_sum = 16'hF579; model_carry = 1'b0; alu_auto = 1'b1;
        s0 = start_count;
        press(4);
        repeat (5) @(negedge clk);
        total++; if (start_count - s0 !== 1) begin bad++; $display("FAIL add_start_pulses got=%0d exp=1", start_count - s0); end
        total++; if (state_dbg !== S_DONE) begin bad++; $display("FAIL add_state_done got=%0d exp=%0d", state_dbg, S_DONE); end
        total++; if (sum !== 16'hF579) begin bad++; $display("FAIL add_sum got=%h exp=F579", sum); end
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL add_finished got=%b exp=1", finished); end
        total++; if (displayValue !== 16'hF579) begin bad++; $display("FAIL add_disp_sum got=%h exp=F579", displayValue); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL add_overflow got=%b exp=0", overflow); end
        total++; if (alu_if.firstNumber !== 16'hF123 || alu_if.secondNumber !== 16'hF456) begin
            bad++; $display("FAIL add_operands_frozen got=%h/%h exp=F123/F456", alu_if.firstNumber, alu_if.secondNumber);
        end
    endtask

    // Runs from DONE with A=F123, B=F456, sum=F579.
    task automatic test_lockout();
        press(0); press(3);
        total++; if (sum !== 16'hF579) begin bad++; $display("FAIL lock_sum got=%h exp=F579", sum); end
        total++; if (alu_if.firstNumber !== 16'hF123) begin bad++; $display("FAIL lock_first got=%h exp=F123", alu_if.firstNumber); end
        total++; if (alu_if.secondNumber !== 16'hF456) begin bad++; $display("FAIL lock_second got=%h exp=F456", alu_if.secondNumber); end
        press(4);
`ifdef BCD_SEQ_AUTOCLEAR_EN
        total++; if (state_dbg !== S_ENTER_A) begin bad++; $display("FAIL clear_state got=%0d exp=%0d", state_dbg, S_ENTER_A); end
        total++; if ({alu_if.firstNumber, alu_if.secondNumber, sum} !== {16'hF000, 16'hF000, 16'hF000}) begin
            bad++; $display("FAIL clear_words got=%h/%h/%h exp=F000/F000/F000", alu_if.firstNumber, alu_if.secondNumber, sum);
        end
        total++; if ({finished, overflow, numberOn} !== 3'b000) begin bad++; $display("FAIL clear_flags got=%b exp=000", {finished, overflow, numberOn}); end
        total++; if (displayValue !== 16'hF000) begin bad++; $display("FAIL clear_disp got=%h exp=F000", displayValue); end
`else
        total++; if (state_dbg !== S_DONE) begin bad++; $display("FAIL lock_enter_state got=%0d exp=%0d", state_dbg, S_DONE); end
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL lock_finished got=%b exp=1", finished); end
        total++; if (displayValue !== 16'hF579) begin bad++; $display("FAIL lock_disp got=%h exp=F579", displayValue); end
`endif
    endtask

    task automatic test_sign_overflow();
        do_reset();
        press_n(2, 7);
        total++; if (alu_if.firstNumber !== 16'hF700) begin bad++; $display("FAIL sgn_first got=%h exp=F700", alu_if.firstNumber); end
        press(4);
        press(3); press_n(2, 2);
        total++; if (alu_if.secondNumber !== 16'hE200) begin bad++; $display("FAIL sgn_second got=%h exp=E200", alu_if.secondNumber); end
        total++; if (displayValue !== 16'hE200) begin bad++; $display("FAIL sgn_disp got=%h exp=E200", displayValue); end
        press(3);
        total++; if (alu_if.secondNumber !== 16'hF200) begin bad++; $display("FAIL sgn_toggle_back got=%h exp=F200", alu_if.secondNumber); end

        do_reset();
        press_n(2, 9); press_n(1, 9); press_n(0, 9);
        total++; if (alu_if.firstNumber !== 16'hF999) begin bad++; $display("FAIL ovf_first got=%h exp=F999", alu_if.firstNumber); end
        press(4);
        press(0);
        total++; if (alu_if.secondNumber !== 16'hF001) begin bad++; $display("FAIL ovf_second got=%h exp=F001", alu_if.secondNumber); end
        model_sum = 16'hF000; model_carry = 1'b1; alu_auto = 1'b1;
        press(4);
        repeat (5) @(negedge clk);
        total++; if (sum !== 16'hF000) begin bad++; $display("FAIL ovf_sum got=%h exp=F000", sum); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL ovf_finished got=%b exp=1", finished); end
        model_carry = 1'b0;
    endtask

    task automatic test_rollover_bounce();
        do_reset();
        // The operand changes on the 7th edge after the first low sample.
        @(negedge clk);
        btn_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (alu_if.firstNumber !== 16'hF000) begin bad++; $display("FAIL lat_early got=%h exp=F000", alu_if.firstNumber); end
        @(negedge clk);
        total++; if (alu_if.firstNumber !== 16'hF001) begin bad++; $display("FAIL lat_edge got=%h exp=F001", alu_if.firstNumber); end
        repeat (3) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        press_n(0, 8);
        total++; if (alu_if.firstNumber !== 16'hF009) begin bad++; $display("FAIL roll_nine got=%h exp=F009", alu_if.firstNumber); end
        press(0);
        total++; if (alu_if.firstNumber !== 16'hF000) begin bad++; $display("FAIL roll_wrap got=%h exp=F000", alu_if.firstNumber); end
        // A 3-cycle glitch is one sample short of the debounce run.
        @(negedge clk);
        btn_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        btn_n[1] = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (alu_if.firstNumber !== 16'hF000) begin bad++; $display("FAIL glitch got=%h exp=F000", alu_if.firstNumber); end
    endtask

    task automatic test_reset_in_wait();
        int n;
        do_reset();
        alu_auto = 1'b0;
        press(4);
        @(negedge clk);
        btn_n[4] = 1'b0;
        n = 0;
        while (state_dbg !== S_WAIT && n < 50) begin @(negedge clk); n++; end
        total++; if (state_dbg !== S_WAIT) begin bad++; $display("FAIL rw_reach_wait got=%0d exp=%0d", state_dbg, S_WAIT); end
        btn_n[4] = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (state_dbg !== S_ENTER_A) begin bad++; $display("FAIL rw_state got=%0d exp=%0d", state_dbg, S_ENTER_A); end
        total++; if (sum !== 16'hF000) begin bad++; $display("FAIL rw_sum got=%h exp=F000", sum); end
        total++; if (finished !== 1'b0) begin bad++; $display("FAIL rw_finished got=%b exp=0", finished); end
        total++; if (displayValue !== 16'hF000) begin bad++; $display("FAIL rw_disp got=%h exp=F000", displayValue); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        btn_n[0] = 1'b0;
        btn_n[4] = 1'b0;
        repeat (10) @(negedge clk);
        btn_n[0] = 1'b1;
        btn_n[4] = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (state_dbg !== S_ENTER_B) begin bad++; $display("FAIL sim_state got=%0d exp=%0d", state_dbg, S_ENTER_B); end
        total++; if (alu_if.firstNumber !== 16'hF000) begin bad++; $display("FAIL sim_first got=%h exp=F000", alu_if.firstNumber); end
        total++; if (alu_if.secondNumber !== 16'hF000) begin bad++; $display("FAIL sim_second got=%h exp=F000", alu_if.secondNumber); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add_123_456();
        test_lockout();
        test_sign_overflow();
        test_rollover_bounce();
        test_reset_in_wait();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
